uart_rx: RTL and testbench
==========================

# uart_rx

UART receive path: recovers serial frames on `i_rx` (1 start, DBIT data LSB-first, no parity, stop period of SB_TICK ticks) using the 16x oversampling strobe from the baud generator. Each completed frame produces a parallel byte with either a one-cycle valid pulse or a framing-error pulse. Sits between the pad-side RX pin and the host-facing receive FIFO. Counterpart of the UART transmitter, sharing the same tick source.

## Interface
- DBIT, default 8: data bits per frame.
- SB_TICK, default 16: ticks in the stop period (16 = 1 stop, 24 = 1.5, 32 = 2).
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_tick  in  1  16x baud strobe, one i_clk cycle wide, from baud generator.
- i_rx  in  1  asynchronous serial input, idle high.
- o_data  out  DBIT  last received word; held until next frame completes.
- o_valid  out  1  one-cycle pulse: frame with good stop bit.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_busy  out  1  high whenever state is not IDLE.

## Operation
- `i_rx` passes through a 2-flop synchronizer (reset value 1) to produce rx_s. All decisions use rx_s.
- Registers:
  - s_cnt: 4 bits, tick counter; widened to $clog2(SB_TICK) if larger.
  - n_cnt: $clog2(DBIT) bits, bit counter.
  - shreg: DBIT bits, shift register.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: i_tick ignored. When rx_s==0, go to START and set s_cnt=0.
- START: on each tick, if s_cnt==7 (mid start bit):
  - rx_s==0: go to DATA; s_cnt=0, n_cnt=0.
  - rx_s==1 (glitch): return to IDLE, with no output pulse.
  - Otherwise s_cnt++.
- DATA: on each tick, if s_cnt==15:
  - s_cnt=0; shreg <= {rx_s, shreg[DBIT-1:1]}.
  - If n_cnt==DBIT-1, go to STOP; else n_cnt++.
  - Otherwise s_cnt++.
- STOP: on each tick, if s_cnt==SB_TICK-1:
  - o_data <= shreg.
  - o_valid <= rx_s; o_frame_err <= ~rx_s.
  - Go to IDLE.
  - Otherwise s_cnt++.
- o_valid and o_frame_err are mutually exclusive. On a framing error, o_data is still updated.
- A line held low (break) produces a frame_err with o_data=0 every frame time. No special break detection.

## Timing
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_busy=0, state=IDLE, synchronizer flops=1, s_cnt=0, n_cnt=0, shreg=0.
- Falling edge on i_rx to o_busy high: 3 i_clk cycles (2 synchronizer + 1 state register).
- o_valid / o_frame_err assert one cycle after the i_clk edge that carries the final STOP tick, and stay high for exactly one cycle.
- Data bit k is sampled at tick 8+16(k+1) after start detection, i.e. bit centre.
- Back-to-back frames: the next frame's start edge may arrive the cycle after STOP exits. IDLE detects it with no lost ticks.
- Reset asserted mid-frame aborts the frame: no pulse, and all registers return to their reset values on that edge.
- i_tick asserted during the same cycle as the IDLE→START transition is not counted.

## Structure
- `uart_pkg`: holds the state enum (IDLE, START, DATA, STOP), OVERSAMPLE=16 and MID_SAMPLE=7. This package is shared with the transmitter.
- Sub-module `sync_2ff`: single-bit synchronizer with a reset-value parameter, instantiated here with value 1.

## Test plan
- Baud gen divisor 3 (tick every 4 cycles, bit = 64 cycles); frame 0x55 → single o_valid, o_data=0x55, o_frame_err=0, o_busy low after exit.
- Frames 0xA3 then 0x0F with zero idle gap → two o_valid pulses exactly 640 cycles apart, data 0xA3 then 0x0F.
- i_rx low for 5 ticks then high → FSM returns to IDLE at tick 8, no pulses, o_busy deasserts.
- Data 0xFF with stop bit driven low → o_frame_err one cycle, o_valid=0, o_data=0xFF.
- Reset pulsed after bit 3 of 0x81, then clean frame 0x3C → no pulse for the aborted frame, o_valid with o_data=0x3C.
- SB_TICK=32, frame 0x81 → o_valid exactly 16 ticks later than the SB_TICK=16 run, o_data=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop recovery with valid or framing-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_tick,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_data,
    output logic            o_valid,
    output logic            o_frame_err,
    output logic            o_busy
);

    // Tick counter must also reach SB_TICK-1 for long stop periods.
    localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = ($clog2(DBIT) > 0) ? $clog2(DBIT) : 1;

    logic rx_s;

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Ticks are ignored here, so a tick on the entry cycle is never counted.
                if (!rx_s) begin
                    state_d = StStart;
                    s_cnt_d = '0;
                end
            end
            StStart: begin
                if (i_tick) begin
                    if (s_cnt_q == SW'(MID_SAMPLE)) begin
                        if (!rx_s) begin
                            state_d = StData;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (i_tick) begin
                    if (s_cnt_q == SW'(OVERSAMPLE - 1)) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        if (n_cnt_q == NW'(DBIT - 1)) begin
                            state_d = StStop;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (i_tick) begin
                    if (s_cnt_q == SW'(SB_TICK - 1)) begin
                        data_d  = shreg_q;
                        valid_d = rx_s;
                        ferr_d  = ~rx_s;
                        state_d = StIdle;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clocks (64 clocks per bit), plus an SB_TICK=32 instance.
module tb_uart_rx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] tdiv  = 2'd0;
    logic       tick;
    logic       line  = 1'b1;
    logic       use_b = 1'b0;
    logic       rx_a, rx_b;
    int         cyc   = 0;

    logic [7:0] a_data, b_data;
    logic       a_valid, a_ferr, a_busy;
    logic       b_valid, b_ferr, b_busy;

    int checks   = 0;
    int failures = 0;

    // Event log for the SB_TICK=16 instance: kind 0 = valid, 1 = frame error, 2 = both.
    int ev_kind[$];
    int ev_data[$];
    int ev_cyc[$];

    int b_cnt      = 0;
    int b_ferr_cnt = 0;
    int b_cyc      = 0;
    int b_last     = 0;

    assign rx_a = line;
    assign rx_b = use_b ? line : 1'b1;
    assign tick = (tdiv == 2'd3);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tdiv <= tdiv + 2'd1;
        cyc  <= cyc + 1;
    end

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tick      (tick),
        .i_rx        (rx_a),
        .o_data      (a_data),
        .o_valid     (a_valid),
        .o_frame_err (a_ferr),
        .o_busy      (a_busy)
    );

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (32)
    ) dut_sb32 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tick      (tick),
        .i_rx        (rx_b),
        .o_data      (b_data),
        .o_valid     (b_valid),
        .o_frame_err (b_ferr),
        .o_busy      (b_busy)
    );

    always @(negedge clk) begin
        if (a_valid || a_ferr) begin
            ev_kind.push_back((a_valid && a_ferr) ? 2 : (a_valid ? 0 : 1));
            ev_data.push_back(int'(a_data));
            ev_cyc.push_back(cyc);
        end
        if (b_valid) begin
            b_cnt  = b_cnt + 1;
            b_cyc  = cyc;
            b_last = int'(b_data);
        end
        if (b_ferr) b_ferr_cnt = b_ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1, so every level lasts exactly n clocks.
    task automatic hold(input logic v, input int n);
        line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] d, input logic stop_val, input int stop_len);
        for (int k = 0; k < 8; k++) hold(d[k], 64);
        hold(stop_val, stop_len);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
        hold(1'b0, 64);
        send_body(d, stop_val, stop_len);
    endtask

    task automatic clear_log();
        ev_kind.delete();
        ev_data.delete();
        ev_cyc.delete();
    endtask

    initial begin
        logic [7:0] d81;
        d81 = 8'h81;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(a_data), 32'h0);
        check("rst_valid", 32'(a_valid), 32'h0);
        check("rst_ferr", 32'(a_ferr), 32'h0);
        check("rst_busy", 32'(a_busy), 32'h0);
        rst_n = 1'b1;
        hold(1'b1, 20);

        // Frame 0x55 with busy latency from the falling edge
        clear_log();
        line = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_lat2", 32'(a_busy), 32'h0);
        @(posedge clk);
        #1;
        check("busy_lat3", 32'(a_busy), 32'h1);
        repeat (61) @(posedge clk);
        #1;
        send_body(8'h55, 1'b1, 64);
        hold(1'b1, 40);
        check("f55_count", 32'(ev_kind.size()), 32'd1);
        if (ev_kind.size() >= 1) begin
            check("f55_kind", 32'(ev_kind[0]), 32'd0);
            check("f55_evdata", 32'(ev_data[0]), 32'h55);
        end
        check("f55_data", 32'(a_data), 32'h55);
        check("f55_busy", 32'(a_busy), 32'h0);

        // Start glitch: low for 5 ticks, rejected at mid start bit
        clear_log();
        hold(1'b0, 20);
        hold(1'b1, 10);
        check("glitch_busy_hi", 32'(a_busy), 32'h1);
        hold(1'b1, 10);
        check("glitch_busy_lo", 32'(a_busy), 32'h0);
        hold(1'b1, 100);
        check("glitch_nopulse", 32'(ev_kind.size()), 32'd0);
        check("glitch_data_held", 32'(a_data), 32'h55);

        // Back-to-back 0xA3, 0x0F
        clear_log();
        send_frame(8'hA3, 1'b1, 64);
        send_frame(8'h0F, 1'b1, 64);
        hold(1'b1, 40);
        check("b2b_count", 32'(ev_kind.size()), 32'd2);
        if (ev_kind.size() >= 2) begin
            check("b2b_kind0", 32'(ev_kind[0]), 32'd0);
            check("b2b_kind1", 32'(ev_kind[1]), 32'd0);
            check("b2b_data0", 32'(ev_data[0]), 32'hA3);
            check("b2b_data1", 32'(ev_data[1]), 32'h0F);
            check("b2b_spacing", 32'(ev_cyc[1] - ev_cyc[0]), 32'd640);
        end

        // 0xFF with stop bit low
        clear_log();
        send_frame(8'hFF, 1'b0, 40);
        hold(1'b1, 200);
        check("ferr_count", 32'(ev_kind.size()), 32'd1);
        if (ev_kind.size() >= 1) begin
            check("ferr_kind", 32'(ev_kind[0]), 32'd1);
        end
        check("ferr_data", 32'(a_data), 32'hFF);
        check("ferr_valid_lo", 32'(a_valid), 32'h0);

        // Reset after bit 3 of 0x81, then clean 0x3C
        clear_log();
        hold(1'b0, 64);
        for (int k = 0; k < 4; k++) hold(d81[k], 64);
        line  = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_data", 32'(a_data), 32'h0);
        check("abort_busy", 32'(a_busy), 32'h0);
        check("abort_valid", 32'(a_valid), 32'h0);
        rst_n = 1'b1;
        hold(1'b1, 100);
        check("abort_nopulse", 32'(ev_kind.size()), 32'd0);
        send_frame(8'h3C, 1'b1, 64);
        hold(1'b1, 40);
        check("f3c_count", 32'(ev_kind.size()), 32'd1);
        if (ev_kind.size() >= 1) begin
            check("f3c_kind", 32'(ev_kind[0]), 32'd0);
            check("f3c_data", 32'(ev_data[0]), 32'h3C);
        end

        // 0x81 into both instances: SB_TICK=32 pulses 16 ticks later
        clear_log();
        b_cnt      = 0;
        b_ferr_cnt = 0;
        use_b      = 1'b1;
        send_frame(8'h81, 1'b1, 128);
        hold(1'b1, 40);
        use_b = 1'b0;
        check("sb16_count", 32'(ev_kind.size()), 32'd1);
        check("sb32_count", 32'(b_cnt), 32'd1);
        check("sb32_ferr", 32'(b_ferr_cnt), 32'd0);
        check("sb32_data", 32'(b_last), 32'h81);
        if (ev_kind.size() >= 1) begin
            check("sb16_data", 32'(ev_data[0]), 32'h81);
            check("sb32_delay", 32'(b_cyc - ev_cyc[0]), 32'd64);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
